load_use_stall_pipe: RTL

Consumer side of the load-use hazard interface. It takes the combinational `stall_signal` from the hazard detector, which compares Rsrc in IF/ID against Rdst in ID/EX and checks the memory-read flag. It then applies the stall to the front of the pipeline: the PC and the IF/ID register are held, and one bubble is injected into the ID/EX control bits. It also handles branch flush, enforces at most one bubble per load, and keeps a saturating bubble counter for performance debug. It sits between the fetch next-PC mux, the IF/ID register and the ID/EX register.

---
 rtl/load_use_stall_pipe.sv | 91 +++++++++
 1 files changed

// File: rtl/load_use_stall_pipe.sv
// rtl/load_use_stall_pipe.sv - applies load-use stall and branch flush to PC, IF/ID and ID/EX control
// HOLD marks the cycle after an injected bubble, so one load never stalls twice.
module load_use_stall_pipe #(
    parameter int INST_W   = 16,
    parameter int PC_W     = 16,
    parameter int CTRL_W   = 8,
    parameter int CNT_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_signal,
    input  logic              flush,
    input  logic [PC_W-1:0]   pc_next,
    input  logic [INST_W-1:0] inst_if,
    input  logic [CTRL_W-1:0] ctrl_id,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] ifid_inst,
    output logic [PC_W-1:0]   ifid_pc,
    output logic              ifid_valid,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INST_W-1:0]  ifid_inst_q, ifid_inst_d;
    logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic               stall_eff;

    // A stall behind an empty IF/ID or right after a bubble would only waste a cycle.
    assign stall_eff = stall_signal & ifid_valid_q & (state_q == RUN) & ~flush;
    assign bubble    = stall_eff | flush;
    assign idex_ctrl = (bubble || !ifid_valid_q) ? '0 : ctrl_id;

    always_comb begin
        state_d       = RUN;
        pc_d          = pc_next;
        ifid_inst_d   = inst_if;
        ifid_pc_d     = pc_q;
        ifid_valid_d  = 1'b1;
        stall_count_d = stall_count_q;
        if (flush) begin
            ifid_inst_d  = '0;
            ifid_pc_d    = '0;
            ifid_valid_d = 1'b0;
        end else if (stall_eff) begin
            state_d      = HOLD;
            pc_d         = pc_q;
            ifid_inst_d  = ifid_inst_q;
            ifid_pc_d    = ifid_pc_q;
            ifid_valid_d = ifid_valid_q;
            if (!(&stall_count_q)) begin
                stall_count_d = stall_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            ifid_inst_q   <= '0;
            ifid_pc_q     <= '0;
            ifid_valid_q  <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_inst_q   <= ifid_inst_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_valid_q  <= ifid_valid_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pc          = pc_q;
    assign ifid_inst   = ifid_inst_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_valid  = ifid_valid_q;
    assign stall_count = stall_count_q;

endmodule
